// File: rtl/tron_fb_pkg.sv
// Shared constants, types and the pixel-to-word address helper for the
// frame-buffer write side.
package tron_fb_pkg;

  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned FB_ROW_WORDS = 320;
  localparam int unsigned FB_WORDS     = 153600;

  typedef enum logic [3:0] {
    COLOR_BLACK = 4'h0,
    COLOR_RED   = 4'h3,
    COLOR_BLUE  = 4'h5,
    COLOR_WHITE = 4'hF
  } fb_color_e;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  // Two pixels share a word, so x is halved; y*320 is built from shifts.
  function automatic logic [18:0] fb_word_addr(input logic [9:0] x, input logic [9:0] y);
    logic [18:0] y19;
    logic [18:0] x19;
    y19 = {9'd0, y};
    x19 = {9'd0, x} >> 1;
    return (y19 << 8) + (y19 << 6) + x19;
  endfunction

endpackage

// File: rtl/fb_clear_sweeper.sv
// Full-screen clear sequencer: owns the IDLE/CLEAR state, the sweep counter
// and the busy/done flags, and offers one clear write per cycle to the top.
module fb_clear_sweeper
  import tron_fb_pkg::fb_state_e, tron_fb_pkg::IDLE, tron_fb_pkg::CLEAR;
#(
  parameter int unsigned FB_WORDS = 153600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done,
  output logic        sweep_we,
  output logic [18:0] sweep_addr
);

  fb_state_e   state_q, state_d;
  logic [18:0] cnt_q, cnt_d;
  logic        done_d;
  logic        all_issued;

  // cnt_q is the next address to write; reaching FB_WORDS means the last
  // write has been issued and one drain cycle remains before done.
  assign all_issued = (cnt_q == 19'(FB_WORDS));
  assign clear_busy = (state_q == CLEAR);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    sweep_we   = 1'b0;
    sweep_addr = cnt_q;
    if (clear_start) begin
      state_d    = CLEAR;
      sweep_we   = 1'b1;
      sweep_addr = '0;
      cnt_d      = 19'd1;
    end else if (state_q == CLEAR) begin
      if (all_issued) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        sweep_we = 1'b1;
        cnt_d    = cnt_q + 19'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clear_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clear_done <= done_d;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Single write port of the frame-buffer RAM, shared between the red and blue
// trail writers and the clear sweeper, with fully registered RAM outputs.
module fb_write_arbiter
  import tron_fb_pkg::SCREEN_W, tron_fb_pkg::SCREEN_H, tron_fb_pkg::fb_word_addr;
#(
  parameter int unsigned FB_WORDS    = 153600,
  parameter logic [3:0]  CLEAR_COLOR = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic        clear_done,
  input  logic        red_req,
  input  logic [9:0]  red_x,
  input  logic [9:0]  red_y,
  input  logic [3:0]  red_color,
  output logic        red_ack,
  input  logic        blue_req,
  input  logic [9:0]  blue_x,
  input  logic [9:0]  blue_y,
  input  logic [3:0]  blue_color,
  output logic        blue_ack,
  output logic        wr_err,
  output logic        fb_we,
  output logic [18:0] fb_addr,
  output logic [15:0] fb_data
);

  logic        sweep_we;
  logic [18:0] sweep_addr;

  logic        rr_red_loses_q, rr_red_loses_d;
  logic        bike_slot, grant_red, grant_blue, sel_bad;
  logic [9:0]  sel_x, sel_y;
  logic [3:0]  sel_color;

  logic        fb_we_d, red_ack_d, blue_ack_d, wr_err_d;
  logic [18:0] fb_addr_d;
  logic [15:0] fb_data_d;

  fb_clear_sweeper #(.FB_WORDS(FB_WORDS)) u_sweeper (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  // Bikes only get the port when no sweep is running or being (re)started.
  always_comb begin
    bike_slot  = !clear_busy && !clear_start;
    grant_red  = bike_slot && red_req && (!blue_req || !rr_red_loses_q);
    grant_blue = bike_slot && blue_req && !grant_red;
    sel_x      = grant_red ? red_x     : blue_x;
    sel_y      = grant_red ? red_y     : blue_y;
    sel_color  = grant_red ? red_color : blue_color;
    sel_bad    = (sel_x >= 10'(SCREEN_W)) || (sel_y >= 10'(SCREEN_H));

    fb_we_d        = 1'b0;
    fb_addr_d      = fb_addr;
    fb_data_d      = fb_data;
    red_ack_d      = 1'b0;
    blue_ack_d     = 1'b0;
    wr_err_d       = 1'b0;
    rr_red_loses_d = rr_red_loses_q;

    if (sweep_we) begin
      fb_we_d   = 1'b1;
      fb_addr_d = sweep_addr;
      fb_data_d = {4'h0, CLEAR_COLOR, 4'h0, CLEAR_COLOR};
    end else if (grant_red || grant_blue) begin
      red_ack_d      = grant_red;
      blue_ack_d     = grant_blue;
      rr_red_loses_d = !rr_red_loses_q;
      // Out-of-range requests are still acked so the requester never stalls.
      if (sel_bad) begin
        wr_err_d = 1'b1;
      end else begin
        fb_we_d   = 1'b1;
        fb_addr_d = fb_word_addr(sel_x, sel_y);
        fb_data_d = {4'h0, sel_color, 4'h0, sel_color};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fb_we          <= 1'b0;
      fb_addr        <= '0;
      fb_data        <= '0;
      red_ack        <= 1'b0;
      blue_ack       <= 1'b0;
      wr_err         <= 1'b0;
      rr_red_loses_q <= 1'b0;
    end else begin
      fb_we          <= fb_we_d;
      fb_addr        <= fb_addr_d;
      fb_data        <= fb_data_d;
      red_ack        <= red_ack_d;
      blue_ack       <= blue_ack_d;
      wr_err         <= wr_err_d;
      rr_red_loses_q <= rr_red_loses_d;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios plus random
// bike traffic, compared cycle by cycle against a behavioural model.
module tb_fb_write_arbiter;

  localparam int unsigned TB_FBW = 1200;
  localparam logic [3:0]  TB_CLR = 4'hA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clear_start = 1'b0;
  logic        clear_busy, clear_done;
  logic        red_req = 1'b0;
  logic [9:0]  red_x = '0, red_y = '0;
  logic [3:0]  red_color = '0;
  logic        red_ack;
  logic        blue_req = 1'b0;
  logic [9:0]  blue_x = '0, blue_y = '0;
  logic [3:0]  blue_color = '0;
  logic        blue_ack;
  logic        wr_err, fb_we;
  logic [18:0] fb_addr;
  logic [15:0] fb_data;

  int n_cmp = 0;
  int n_err = 0;

  bit m_on;
  int m_next;
  bit m_red_wins;
  logic        e_we, e_rack, e_back, e_err, e_busy, e_done;
  logic [18:0] e_addr;
  logic [15:0] e_data;

  bit r_pend, b_pend;
  int writes, dones, done_at, ack_at;

  fb_write_arbiter #(.FB_WORDS(TB_FBW), .CLEAR_COLOR(TB_CLR)) dut (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .red_req(red_req), .red_x(red_x), .red_y(red_y), .red_color(red_color), .red_ack(red_ack),
    .blue_req(blue_req), .blue_x(blue_x), .blue_y(blue_y), .blue_color(blue_color), .blue_ack(blue_ack),
    .wr_err(wr_err), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Spec-level model: a running sweep writes one word per cycle in order,
  // then spends one cycle signalling done; otherwise bikes share by round-robin.
  function automatic void model_step();
    bit pick_red;
    int xi, yi;
    logic [3:0] c;
    e_we = 1'b0; e_rack = 1'b0; e_back = 1'b0; e_err = 1'b0; e_done = 1'b0;
    if (clear_start) begin
      m_on = 1'b1; m_next = 1;
      e_we = 1'b1; e_addr = '0; e_data = {2{4'h0, TB_CLR}};
    end else if (m_on) begin
      if (m_next < int'(TB_FBW)) begin
        e_we = 1'b1; e_addr = 19'(m_next); e_data = {2{4'h0, TB_CLR}};
        m_next++;
      end else begin
        m_on = 1'b0; e_done = 1'b1;
      end
    end else if (red_req || blue_req) begin
      pick_red = red_req && (!blue_req || m_red_wins);
      xi = pick_red ? int'(red_x) : int'(blue_x);
      yi = pick_red ? int'(red_y) : int'(blue_y);
      c  = pick_red ? red_color : blue_color;
      if (pick_red) e_rack = 1'b1; else e_back = 1'b1;
      m_red_wins = !m_red_wins;
      if (xi >= 640 || yi >= 480) begin
        e_err = 1'b1;
      end else begin
        e_we = 1'b1; e_addr = 19'(yi * 320 + xi / 2); e_data = {4'h0, c, 4'h0, c};
      end
    end
    e_busy = m_on;
  endfunction

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("fb_we", fb_we, e_we);
    check("red_ack", red_ack, e_rack);
    check("blue_ack", blue_ack, e_back);
    check("wr_err", wr_err, e_err);
    check("clear_busy", clear_busy, e_busy);
    check("clear_done", clear_done, e_done);
    if (e_we) begin
      check("fb_addr", fb_addr, e_addr);
      check("fb_data", fb_data, e_data);
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    m_on = 1'b0; m_next = 0; m_red_wins = 1'b1;
    e_addr = '0; e_data = '0;
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_red_ack", red_ack, 0);
    check("rst_blue_ack", blue_ack, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_clear_done", clear_done, 0);
    clear_start = 1'b0; red_req = 1'b0; blue_req = 1'b0;
    r_pend = 1'b0; b_pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [9:0] rand_x();
    return ($urandom_range(0, 7) == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(0, 639));
  endfunction

  function automatic logic [9:0] rand_y();
    return ($urandom_range(0, 7) == 0) ? 10'($urandom_range(480, 1023)) : 10'($urandom_range(0, 479));
  endfunction

  // Requesters hold their request until acked, then idle or issue a new one.
  task automatic drive_random(input int clear_odds);
    clear_start = (clear_odds > 0) && ($urandom_range(0, clear_odds - 1) == 0);
    if (!r_pend) begin
      if ($urandom_range(0, 2) != 0) begin
        r_pend = 1'b1; red_req = 1'b1;
        red_x = rand_x(); red_y = rand_y(); red_color = 4'($urandom_range(0, 15));
      end else red_req = 1'b0;
    end
    if (!b_pend) begin
      if ($urandom_range(0, 2) != 0) begin
        b_pend = 1'b1; blue_req = 1'b1;
        blue_x = rand_x(); blue_y = rand_y(); blue_color = 4'($urandom_range(0, 15));
      end else blue_req = 1'b0;
    end
  endtask

  task automatic run_random(input int n, input int clear_odds);
    for (int i = 0; i < n; i++) begin
      drive_random(clear_odds);
      cycle();
      if (red_ack) r_pend = 1'b0;
      if (blue_ack) b_pend = 1'b0;
    end
    clear_start = 1'b0; red_req = 1'b0; blue_req = 1'b0;
    r_pend = 1'b0; b_pend = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    apply_reset();

    // Single red write at (3,2).
    red_req = 1'b1; red_x = 10'd3; red_y = 10'd2; red_color = 4'h3;
    cycle();
    check("red641_ack", red_ack, 1);
    check("red641_we", fb_we, 1);
    check("red641_addr", fb_addr, 641);
    check("red641_data", fb_data, 16'h0303);
    red_req = 1'b0;
    cycle();

    // Both bikes held: grants alternate starting with red.
    apply_reset();
    red_req = 1'b1; red_x = 10'd10; red_y = 10'd20; red_color = 4'h3;
    blue_req = 1'b1; blue_x = 10'd11; blue_y = 10'd21; blue_color = 4'h5;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rr_red", red_ack, (i % 2 == 0) ? 1 : 0);
      check("rr_blue", blue_ack, (i % 2 == 1) ? 1 : 0);
    end
    red_req = 1'b0;

    // Range boundaries on the blue port.
    blue_x = 10'd640; blue_y = 10'd10;
    cycle();
    check("oor_x_ack", blue_ack, 1);
    check("oor_x_err", wr_err, 1);
    check("oor_x_we", fb_we, 0);
    blue_x = 10'd639; blue_y = 10'd479;
    cycle();
    check("max_addr", fb_addr, 153599);
    check("max_err", wr_err, 0);
    blue_x = 10'd0; blue_y = 10'd480;
    cycle();
    check("oor_y_err", wr_err, 1);
    blue_req = 1'b0;
    cycle();

    // Full sweep with blue held off until after done.
    clear_start = 1'b1;
    blue_req = 1'b1; blue_x = 10'd100; blue_y = 10'd100; blue_color = 4'h5;
    cycle();
    check("clr_first_addr", fb_addr, 0);
    check("clr_first_noack", blue_ack, 0);
    clear_start = 1'b0;
    writes = 1; dones = 0; done_at = -1; ack_at = -1;
    for (int k = 2; k <= int'(TB_FBW) + 4; k++) begin
      cycle();
      if (fb_we && clear_busy) writes++;
      if (clear_done) begin dones++; done_at = k; end
      if (blue_ack && ack_at < 0) begin ack_at = k; blue_req = 1'b0; end
    end
    check("clr_writes", writes, TB_FBW);
    check("clr_done_count", dones, 1);
    check("clr_done_cycle", done_at, TB_FBW + 1);
    check("clr_blue_ack_cycle", ack_at, TB_FBW + 2);

    // Restart the sweep after 1000 words.
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    dones = 0;
    for (int k = 0; k < 999; k++) begin
      cycle();
      if (clear_done) dones++;
    end
    check("restart_pre_addr", fb_addr, 999);
    clear_start = 1'b1;
    cycle();
    check("restart_addr", fb_addr, 0);
    clear_start = 1'b0;
    done_at = -1;
    for (int k = 2; k <= int'(TB_FBW) + 3; k++) begin
      cycle();
      if (clear_done) begin dones++; done_at = k; end
    end
    check("restart_done_count", dones, 1);
    check("restart_done_cycle", done_at, TB_FBW + 1);

    // Reset in the middle of a sweep, then normal bike service.
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    for (int k = 0; k < 50; k++) cycle();
    apply_reset();
    red_req = 1'b1; red_x = 10'd5; red_y = 10'd5; red_color = 4'h3;
    cycle();
    check("post_rst_ack", red_ack, 1);
    red_req = 1'b0;
    run_random(400, 0);

    // Random traffic with occasional clears.
    run_random(3000, 500);
    for (int k = 0; k < int'(TB_FBW) + 4; k++) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
